// File: rtl/run_sequencer_if.sv
// Run-controller bus bundle: host access port, core control/memory port,
// data-memory port and run status.
// slave modport: the run_sequencer side; master modport: the environment
// (host, core and memory) side.
interface run_sequencer_if #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
);
  // host side
  logic          start;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  // core side
  logic          core_done;
  logic          core_dm_we;
  logic [AW-1:0] core_dm_addr;
  logic [DW-1:0] core_dm_wdata;
  logic          core_rst;
  logic          core_en;
  // data memory side
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  // status
  logic [CW-1:0] cycle_count;
  logic          busy;
  logic          finished;
  logic          timeout;

  modport slave (
    input  start, host_req, host_we, host_addr, host_wdata,
    input  core_done, core_dm_we, core_dm_addr, core_dm_wdata,
    input  dm_rdata,
    output host_gnt, host_rdata, core_rst, core_en,
    output dm_we, dm_addr, dm_wdata,
    output cycle_count, busy, finished, timeout
  );

  modport master (
    output start, host_req, host_we, host_addr, host_wdata,
    output core_done, core_dm_we, core_dm_addr, core_dm_wdata,
    output dm_rdata,
    input  host_gnt, host_rdata, core_rst, core_en,
    input  dm_we, dm_addr, dm_wdata,
    input  cycle_count, busy, finished, timeout
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller: owns core reset/enable, arbitrates the single data-memory
// port between host (parked core) and core (running), counts run cycles,
// detects done, enforces a MAX_CYCLES timeout.
// Latency: memory mux is combinational on current state; state changes take
// effect at the next clk edge. Backpressure: host requests outside IDLE/DONE
// are not granted and are dropped (host retries until host_gnt).
// Ports: clk, reset (async, active high), bus (run_sequencer_if.slave).
module run_sequencer #(
  parameter int          AW          = 8,
  parameter int          DW          = 8,
  parameter int          CW          = 16,
  parameter int          BOOT_CYCLES = 2,
  parameter int unsigned MAX_CYCLES  = 16'hFFFF
) (
  input  logic clk,
  input  logic reset,
  run_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, BOOT, RUN, DRAIN, DONE} state_t;

  // boot counter runs 0 .. BOOT_CYCLES-1
  localparam int            BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_CYCLES);

  state_t        state, state_nxt;
  logic [BW-1:0] boot_cnt, boot_cnt_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          to, to_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      boot_cnt <= '0;
      cnt      <= '0;
      to       <= 1'b0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      cnt      <= cnt_nxt;
      to       <= to_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    cnt_nxt      = cnt;
    to_nxt       = to;
    cnt_inc      = cnt + 1'b1;

    bus.core_rst   = 1'b1;
    bus.core_en    = 1'b0;
    bus.busy       = 1'b0;
    bus.finished   = 1'b0;
    bus.host_gnt   = 1'b0;
    bus.host_rdata = '0;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;

    case (state)
      IDLE, DONE: begin
        // DONE keeps the core out of reset so its state can be inspected
        bus.core_rst   = (state == IDLE);
        bus.finished   = (state == DONE);
        bus.host_gnt   = bus.host_req;
        bus.dm_addr    = bus.host_addr;
        bus.dm_wdata   = bus.host_wdata;
        bus.dm_we      = bus.host_req & bus.host_we;
        bus.host_rdata = bus.host_req ? bus.dm_rdata : '0;
        if (bus.start) begin
          state_nxt    = BOOT;
          boot_cnt_nxt = '0;
          cnt_nxt      = '0;
          to_nxt       = 1'b0;
        end
      end
      BOOT: begin
        bus.busy = 1'b1;
        if (boot_cnt == BOOT_LAST) state_nxt = RUN;
        else                       boot_cnt_nxt = boot_cnt + 1'b1;
      end
      RUN: begin
        bus.core_rst = 1'b0;
        bus.core_en  = 1'b1;
        bus.busy     = 1'b1;
        bus.dm_we    = bus.core_dm_we;
        bus.dm_addr  = bus.core_dm_addr;
        bus.dm_wdata = bus.core_dm_wdata;
        // done takes priority over the limit and freezes the count
        if (bus.core_done) begin
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == MAX_C) begin
            state_nxt = DRAIN;
            to_nxt    = 1'b1;
          end
        end
      end
      DRAIN: begin
        bus.core_rst = 1'b0;
        bus.busy     = 1'b1;
        state_nxt    = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cycle_count = cnt;
  assign bus.timeout     = to;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  mem[256];

  run_sequencer_if #(.AW(8), .DW(8), .CW(16)) bm ();
  run_sequencer_if #(.AW(8), .DW(8), .CW(16)) b5 ();
  run_sequencer_if #(.AW(8), .DW(8), .CW(16)) b4 ();

  run_sequencer u_main (.clk(clk), .reset(reset), .bus(bm.slave));
  run_sequencer #(.MAX_CYCLES(5)) u_t5 (.clk(clk), .reset(reset), .bus(b5.slave));
  run_sequencer #(.MAX_CYCLES(4)) u_t4 (.clk(clk), .reset(reset), .bus(b4.slave));

  // memory model for the main instance, combinational read
  always @(posedge clk) if (bm.dm_we) mem[bm.dm_addr] <= bm.dm_wdata;
  assign bm.dm_rdata = mem[bm.dm_addr];
  assign b5.dm_rdata = '0;
  assign b4.dm_rdata = '0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic host_xfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           output logic gnt, output logic [7:0] rdata);
    @(negedge clk);
    bm.host_req = 1'b1; bm.host_we = we; bm.host_addr = addr; bm.host_wdata = wdata;
    #1;
    gnt = bm.host_gnt; rdata = bm.host_rdata;
    @(posedge clk); #1;
    bm.host_req = 1'b0; bm.host_we = 1'b0;
  endtask

  task automatic test_reset();
    logic g; logic [7:0] r; logic [15:0] e;
    @(negedge clk); reset = 1'b1; #1;
    vectors++; if (bm.core_rst !== 1'b1) begin miscompares++; $display("FAIL rst_core_rst: got %b want 1", bm.core_rst); end
    vectors++; if (bm.core_en !== 1'b0) begin miscompares++; $display("FAIL rst_core_en: got %b want 0", bm.core_en); end
    vectors++; if (bm.busy !== 1'b0 || bm.finished !== 1'b0) begin miscompares++; $display("FAIL rst_status: busy %b finished %b want 0 0", bm.busy, bm.finished); end
    vectors++; if (bm.cycle_count !== 16'd0 || bm.timeout !== 1'b0) begin miscompares++; $display("FAIL rst_count: count %0d timeout %b want 0 0", bm.cycle_count, bm.timeout); end
    @(negedge clk); reset = 1'b0;
    host_xfer(1'b1, 8'd9, 8'd3, g, r);
    vectors++; if (g !== 1'b1) begin miscompares++; $display("FAIL idle_wr_gnt: got %b want 1", g); end
    exp_q.push_back(16'd3);
    host_xfer(1'b0, 8'd9, 8'd0, g, r);
    e = exp_q.pop_front();
    vectors++; if (g !== 1'b1) begin miscompares++; $display("FAIL idle_rd_gnt: got %b want 1", g); end
    vectors++; if (r !== e[7:0]) begin miscompares++; $display("FAIL idle_rd_data: got %h want %h", r, e[7:0]); end
  endtask

  task automatic test_normal_run();
    int boots, runs, drains; logic [15:0] e;
    boots = 0; runs = 0; drains = 0;
    exp_q.push_back(16'd10); exp_q.push_back(16'd0);
    @(negedge clk); bm.start = 1'b1;
    @(negedge clk); bm.start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bm.finished === 1'b1) break;
      if (bm.busy && bm.core_rst) boots++;
      else if (bm.core_en) begin
        runs++;
        vectors++; if (bm.cycle_count !== 16'(runs - 1)) begin miscompares++; $display("FAIL run_count_trace: cycle %0d got %0d want %0d", runs, bm.cycle_count, runs - 1); end
        // start mid-run must be ignored; done is raised in the RUN cycle after 10 counted cycles
        bm.start = (runs == 5);
        bm.core_done = (runs == 11);
      end else if (bm.busy) begin drains++; bm.start = 1'b0; end
      @(negedge clk);
    end
    bm.core_done = 1'b0; bm.start = 1'b0;
    vectors++; if (bm.finished !== 1'b1) begin miscompares++; $display("FAIL run_finish: got %b want 1 within budget", bm.finished); end
    vectors++; if (boots != 2) begin miscompares++; $display("FAIL run_boot_cycles: got %0d want 2", boots); end
    // the done cycle is itself an enabled RUN cycle: 10 counted + 1
    vectors++; if (runs != 11) begin miscompares++; $display("FAIL run_en_cycles: got %0d want 11", runs); end
    vectors++; if (drains != 1) begin miscompares++; $display("FAIL run_drain_cycles: got %0d want 1", drains); end
    e = exp_q.pop_front();
    vectors++; if (bm.cycle_count !== e) begin miscompares++; $display("FAIL run_count: got %0d want %0d", bm.cycle_count, e); end
    e = exp_q.pop_front();
    vectors++; if (bm.timeout !== e[0]) begin miscompares++; $display("FAIL run_timeout: got %b want %b", bm.timeout, e[0]); end
    vectors++; if (bm.core_rst !== 1'b0 || bm.core_en !== 1'b0 || bm.busy !== 1'b0) begin miscompares++; $display("FAIL done_ctrl: rst %b en %b busy %b want 0 0 0", bm.core_rst, bm.core_en, bm.busy); end
  endtask

  task automatic test_arbitration();
    int runs; logic g; logic [7:0] r; logic [15:0] e;
    runs = 0;
    @(negedge clk); bm.start = 1'b1;
    @(negedge clk); bm.start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bm.finished === 1'b1) break;
      if (bm.core_en) begin
        runs++;
        if (runs == 1) begin
          bm.core_dm_we = 1'b1; bm.core_dm_addr = 8'd1; bm.core_dm_wdata = 8'h08;
          bm.host_req = 1'b1; bm.host_we = 1'b1; bm.host_addr = 8'd1; bm.host_wdata = 8'h55;
          #1;
          vectors++; if (bm.host_gnt !== 1'b0 || bm.host_rdata !== 8'h00) begin miscompares++; $display("FAIL arb_run_gnt: gnt %b rdata %h want 0 00", bm.host_gnt, bm.host_rdata); end
          vectors++; if (bm.dm_we !== 1'b1 || bm.dm_addr !== 8'd1 || bm.dm_wdata !== 8'h08) begin miscompares++; $display("FAIL arb_run_core: we %b addr %0d data %h want 1 1 08", bm.dm_we, bm.dm_addr, bm.dm_wdata); end
        end else begin
          bm.core_dm_we = 1'b0; bm.host_req = 1'b0; bm.host_we = 1'b0;
        end
        bm.core_done = (runs == 3);
      end else if (bm.busy && !bm.core_rst) begin
        bm.core_dm_we = 1'b1; #1;
        vectors++; if (bm.dm_we !== 1'b0) begin miscompares++; $display("FAIL arb_drain_we: got %b want 0", bm.dm_we); end
        bm.core_dm_we = 1'b0;
      end
      @(negedge clk);
    end
    bm.core_done = 1'b0; bm.core_dm_we = 1'b0;
    vectors++; if (bm.finished !== 1'b1) begin miscompares++; $display("FAIL arb_finish: got %b want 1", bm.finished); end
    exp_q.push_back(16'h08);
    host_xfer(1'b0, 8'd1, 8'd0, g, r);
    e = exp_q.pop_front();
    vectors++; if (g !== 1'b1 || r !== e[7:0]) begin miscompares++; $display("FAIL arb_core_wrote: gnt %b data %h want 1 %h", g, r, e[7:0]); end
    host_xfer(1'b1, 8'd1, 8'h55, g, r);
    vectors++; if (g !== 1'b1) begin miscompares++; $display("FAIL arb_done_wr_gnt: got %b want 1", g); end
    // core write while parked must not reach memory
    @(negedge clk); bm.core_dm_we = 1'b1; bm.core_dm_addr = 8'd1; bm.core_dm_wdata = 8'hAA; #1;
    vectors++; if (bm.dm_we !== 1'b0) begin miscompares++; $display("FAIL arb_done_core_we: got %b want 0", bm.dm_we); end
    @(posedge clk); #1; bm.core_dm_we = 1'b0;
    exp_q.push_back(16'h55);
    host_xfer(1'b0, 8'd1, 8'd0, g, r);
    e = exp_q.pop_front();
    vectors++; if (r !== e[7:0]) begin miscompares++; $display("FAIL arb_overwrite: got %h want %h", r, e[7:0]); end
  endtask

  task automatic test_timeout();
    int runs; logic [15:0] e;
    runs = 0;
    exp_q.push_back(16'd5); exp_q.push_back(16'd1);
    @(negedge clk); b5.start = 1'b1;
    @(negedge clk); b5.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b5.finished === 1'b1) break;
      if (b5.core_en) runs++;
      @(negedge clk);
    end
    vectors++; if (b5.finished !== 1'b1 || runs != 5) begin miscompares++; $display("FAIL to_run_cycles: finished %b runs %0d want 1 5", b5.finished, runs); end
    e = exp_q.pop_front();
    vectors++; if (b5.cycle_count !== e) begin miscompares++; $display("FAIL to_count: got %0d want %0d", b5.cycle_count, e); end
    e = exp_q.pop_front();
    vectors++; if (b5.timeout !== e[0]) begin miscompares++; $display("FAIL to_flag: got %b want %b", b5.timeout, e[0]); end
    // a new run clears timeout and count on BOOT entry
    @(negedge clk); b5.start = 1'b1;
    @(negedge clk); b5.start = 1'b0;
    vectors++; if (b5.timeout !== 1'b0 || b5.cycle_count !== 16'd0 || b5.finished !== 1'b0) begin miscompares++; $display("FAIL to_boot_clear: timeout %b count %0d finished %b want 0 0 0", b5.timeout, b5.cycle_count, b5.finished); end
    for (int c = 0; c < 40; c++) begin
      if (b5.finished === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_collision();
    int runs;
    runs = 0;
    @(negedge clk); b4.start = 1'b1;
    @(negedge clk); b4.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b4.finished === 1'b1) break;
      if (b4.core_en) begin runs++; b4.core_done = (runs == 4); end
      @(negedge clk);
    end
    b4.core_done = 1'b0;
    vectors++; if (b4.finished !== 1'b1 || runs != 4) begin miscompares++; $display("FAIL col_run_cycles: finished %b runs %0d want 1 4", b4.finished, runs); end
    vectors++; if (b4.timeout !== 1'b0 || b4.cycle_count !== 16'd3) begin miscompares++; $display("FAIL col_result: timeout %b count %0d want 0 3", b4.timeout, b4.cycle_count); end
  endtask

  task automatic test_reset_midrun();
    int runs; logic g; logic [7:0] r; logic [15:0] e;
    runs = 0;
    @(negedge clk); bm.start = 1'b1;
    @(negedge clk); bm.start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bm.core_en) begin
        runs++;
        if (runs == 3) begin
          bm.core_dm_we = 1'b1; bm.core_dm_addr = 8'd5; bm.core_dm_wdata = 8'h77;
          reset = 1'b1; #1;
          vectors++; if (bm.core_rst !== 1'b1 || bm.core_en !== 1'b0 || bm.busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ctrl: rst %b en %b busy %b want 1 0 0", bm.core_rst, bm.core_en, bm.busy); end
          vectors++; if (bm.dm_we !== 1'b0 || bm.cycle_count !== 16'd0) begin miscompares++; $display("FAIL mid_rst_mem: dm_we %b count %0d want 0 0", bm.dm_we, bm.cycle_count); end
          break;
        end
      end
      @(negedge clk);
    end
    vectors++; if (runs != 3) begin miscompares++; $display("FAIL mid_reach_run: runs %0d want 3", runs); end
    @(negedge clk); reset = 1'b0; bm.core_dm_we = 1'b0;
    // restart with a host write in the same cycle start is sampled
    @(negedge clk);
    bm.start = 1'b1; bm.host_req = 1'b1; bm.host_we = 1'b1; bm.host_addr = 8'd7; bm.host_wdata = 8'h42; #1;
    vectors++; if (bm.host_gnt !== 1'b1) begin miscompares++; $display("FAIL restart_host_gnt: got %b want 1", bm.host_gnt); end
    @(negedge clk); bm.start = 1'b0; bm.host_req = 1'b0; bm.host_we = 1'b0;
    vectors++; if (bm.busy !== 1'b1 || bm.core_rst !== 1'b1) begin miscompares++; $display("FAIL restart_boot: busy %b rst %b want 1 1", bm.busy, bm.core_rst); end
    exp_q.push_back(16'd6);
    runs = 0;
    for (int c = 0; c < 60; c++) begin
      if (bm.finished === 1'b1) break;
      if (bm.core_en) begin
        runs++;
        vectors++; if (bm.cycle_count !== 16'(runs - 1)) begin miscompares++; $display("FAIL restart_count_trace: cycle %0d got %0d want %0d", runs, bm.cycle_count, runs - 1); end
        bm.core_done = (runs == 7);
      end
      @(negedge clk);
    end
    bm.core_done = 1'b0;
    e = exp_q.pop_front();
    vectors++; if (bm.finished !== 1'b1 || bm.cycle_count !== e || bm.timeout !== 1'b0) begin miscompares++; $display("FAIL restart_result: finished %b count %0d timeout %b want 1 %0d 0", bm.finished, bm.cycle_count, bm.timeout, e); end
    exp_q.push_back(16'h42);
    host_xfer(1'b0, 8'd7, 8'd0, g, r);
    e = exp_q.pop_front();
    vectors++; if (g !== 1'b1 || r !== e[7:0]) begin miscompares++; $display("FAIL restart_host_data: gnt %b data %h want 1 %h", g, r, e[7:0]); end
  endtask

  initial begin
    reset = 1'b1;
    bm.start = 0; bm.host_req = 0; bm.host_we = 0; bm.host_addr = '0; bm.host_wdata = '0;
    bm.core_done = 0; bm.core_dm_we = 0; bm.core_dm_addr = '0; bm.core_dm_wdata = '0;
    b5.start = 0; b5.host_req = 0; b5.host_we = 0; b5.host_addr = '0; b5.host_wdata = '0;
    b5.core_done = 0; b5.core_dm_we = 0; b5.core_dm_addr = '0; b5.core_dm_wdata = '0;
    b4.start = 0; b4.host_req = 0; b4.host_we = 0; b4.host_addr = '0; b4.host_wdata = '0;
    b4.core_done = 0; b4.core_dm_we = 0; b4.core_dm_addr = '0; b4.core_dm_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_normal_run();
    test_arbitration();
    test_timeout();
    test_collision();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
